stage_mem_dp: RTL and testbench

STAGE_MEM_DP -- requirements
Module: stage_mem_dp

---
 rtl/stage_mem_pkg.sv | 17 +
 rtl/stage_mem_ram.sv | 34 +++
 rtl/stage_mem_dp.sv | 194 +++++++++++++++++++
 tb/tb_stage_mem_dp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// Shared types and helpers for the stage_mem_dp lookup memory.
// Lane parity is used only when STAGE_MEM_PARITY_EN is defined.
package stage_mem_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int unsigned LANE_MAX_W = 32;

   // Even parity over one lane; callers zero-extend the lane to LANE_MAX_W.
   function automatic logic lane_parity(input logic [LANE_MAX_W-1:0] lane);
      return ^lane;
   endfunction

endpackage

// File: rtl/stage_mem_ram.sv
// Reset-less simple dual-port array: one write port with per-lane enables,
// one registered read port (read-during-write returns old contents).
module stage_mem_ram
   import stage_mem_pkg::*;
#(
   parameter int unsigned NB   = 8,
   parameter int unsigned LW   = 9,
   parameter int unsigned ADDR = 10
) (
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [ADDR-1:0]    i_waddr,
   input  logic [NB*LW-1:0]   i_wdata,
   input  logic [NB-1:0]      i_wbe,
   input  logic               i_re,
   input  logic [ADDR-1:0]    i_raddr,
   output logic [NB*LW-1:0]   o_rdata
);

   logic [NB*LW-1:0] r_mem [2**ADDR];
   logic [NB*LW-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (i_wbe[i]) r_mem[i_waddr][i*LW +: LW] <= i_wdata[i*LW +: LW];
         end
      end
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/stage_mem_dp.sv
// Lookup/update dual-port memory with self-clearing INIT, write-first bypass
// and a READ_LATENCY pipeline. Define STAGE_MEM_PARITY_EN for lane parity.
module stage_mem_dp
   import stage_mem_pkg::*;
#(
   parameter int unsigned DATA         = 72,
   parameter int unsigned ADDR         = 10,
   parameter int unsigned BYTE_W       = 9,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rd_en,
   input  logic [ADDR-1:0]        rd_addr,
   output logic                   rd_valid,
   output logic [DATA-1:0]        rd_data,
   input  logic                   wr_en,
   input  logic [ADDR-1:0]        wr_addr,
   input  logic [DATA-1:0]        wr_data,
   input  logic [DATA/BYTE_W-1:0] wr_be,
   output logic                   init_done,
   output logic                   parity_err
);

   localparam int unsigned NB = DATA / BYTE_W;
`ifdef STAGE_MEM_PARITY_EN
   localparam int unsigned LW = BYTE_W + 1;
`else
   localparam int unsigned LW = BYTE_W;
`endif
   localparam int unsigned SW = NB * LW;

   state_t            r_state, w_state_nxt;
   logic [ADDR-1:0]   r_cnt, w_cnt_nxt;
   logic              r_init_done;
   logic              w_init_we;

   logic              w_rd_acc, w_wr_acc, w_collide;
   logic [SW-1:0]     w_wr_word;
   logic              w_ram_we;
   logic [ADDR-1:0]   w_ram_waddr;
   logic [SW-1:0]     w_ram_wdata;
   logic [NB-1:0]     w_ram_wbe;
   logic [SW-1:0]     w_ram_q;

   logic              r_s1_valid;
   logic [NB-1:0]     r_s1_mask;
   logic [SW-1:0]     r_s1_wword;
   logic [SW-1:0]     w_s1_word;

   logic              w_out_valid;
   logic [SW-1:0]     w_out_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_INIT;
         r_cnt       <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_init_done <= (r_state == ST_RUN);
      end
   end

   // Counter holds at the last address so the final INIT write never wraps.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_init_we   = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_init_we = 1'b1;
            if (r_cnt == '1) w_state_nxt = ST_RUN;
            else             w_cnt_nxt   = r_cnt + ADDR'(1);
         end
         ST_RUN:  ;
         default: w_state_nxt = ST_INIT;
      endcase
   end

   assign init_done = r_init_done;
   assign w_rd_acc  = rd_en & r_init_done;
   assign w_wr_acc  = wr_en & r_init_done;
   assign w_collide = w_rd_acc & w_wr_acc & (rd_addr == wr_addr);

   always_comb begin
      w_wr_word = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         w_wr_word[i*LW +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
`ifdef STAGE_MEM_PARITY_EN
         w_wr_word[i*LW + BYTE_W] = lane_parity(LANE_MAX_W'(wr_data[i*BYTE_W +: BYTE_W]));
`endif
      end
   end

   assign w_ram_we    = w_init_we | w_wr_acc;
   assign w_ram_waddr = w_init_we ? r_cnt : wr_addr;
   assign w_ram_wdata = w_init_we ? '0 : w_wr_word;
   assign w_ram_wbe   = w_init_we ? '1 : wr_be;

   stage_mem_ram #(
      .NB   (NB),
      .LW   (LW),
      .ADDR (ADDR)
   ) u_ram (
      .i_clk   (clk),
      .i_we    (w_ram_we),
      .i_waddr (w_ram_waddr),
      .i_wdata (w_ram_wdata),
      .i_wbe   (w_ram_wbe),
      .i_re    (w_rd_acc),
      .i_raddr (rd_addr),
      .o_rdata (w_ram_q)
   );

   // The array returns old contents on a collision; lanes written in the
   // same cycle are substituted here from the captured write word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_mask  <= '0;
         r_s1_wword <= '0;
      end else begin
         r_s1_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_s1_mask  <= w_collide ? wr_be : '0;
            r_s1_wword <= w_wr_word;
         end
      end
   end

   always_comb begin
      w_s1_word = w_ram_q;
      for (int unsigned i = 0; i < NB; i++) begin
         if (r_s1_mask[i]) w_s1_word[i*LW +: LW] = r_s1_wword[i*LW +: LW];
      end
   end

   generate
      if (READ_LATENCY == 1) begin : g_lat1
         logic r_seen;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)          r_seen <= 1'b0;
            else if (r_s1_valid) r_seen <= 1'b1;
         end
         assign w_out_valid = r_s1_valid;
         assign w_out_word  = (r_seen | r_s1_valid) ? w_s1_word : '0;
      end else begin : g_latn
         logic [READ_LATENCY-2:0] r_pv;
         logic [SW-1:0]           r_pw [READ_LATENCY-1];
         // Each stage only loads on a valid word, so the output holds when idle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_pv <= '0;
               for (int unsigned k = 0; k < READ_LATENCY-1; k++) r_pw[k] <= '0;
            end else begin
               r_pv[0] <= r_s1_valid;
               if (r_s1_valid) r_pw[0] <= w_s1_word;
               for (int unsigned k = 1; k < READ_LATENCY-1; k++) begin
                  r_pv[k] <= r_pv[k-1];
                  if (r_pv[k-1]) r_pw[k] <= r_pw[k-1];
               end
            end
         end
         assign w_out_valid = r_pv[READ_LATENCY-2];
         assign w_out_word  = r_pw[READ_LATENCY-2];
      end
   endgenerate

   assign rd_valid = w_out_valid;

`ifdef STAGE_MEM_PARITY_EN
   logic w_par_mis;
   always_comb begin
      rd_data   = '0;
      w_par_mis = 1'b0;
      for (int unsigned i = 0; i < NB; i++) begin
         rd_data[i*BYTE_W +: BYTE_W] = w_out_word[i*LW +: BYTE_W];
         w_par_mis = w_par_mis | (^w_out_word[i*LW +: LW]);
      end
   end
   assign parity_err = w_out_valid & w_par_mis;
`else
   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         rd_data[i*BYTE_W +: BYTE_W] = w_out_word[i*LW +: BYTE_W];
      end
   end
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_stage_mem_dp.sv
// Directed bench for stage_mem_dp (ADDR=4, READ_LATENCY=3); the parity
// backdoor case is compiled only with STAGE_MEM_PARITY_EN.
module tb_stage_mem_dp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd_en;
   logic [3:0]  rd_addr;
   logic        rd_valid;
   logic [71:0] rd_data;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [71:0] wr_data;
   logic [7:0]  wr_be;
   logic        init_done;
   logic        parity_err;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [71:0] mdl [16];
   logic [15:0] bad_lane0;
   logic        pv [3];
   logic [71:0] pd [3];
   logic        pp [3];
   logic [71:0] last_data;

   always #5 clk = ~clk;

   stage_mem_dp #(
      .DATA         (72),
      .ADDR         (4),
      .BYTE_W       (9),
      .READ_LATENCY (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_be      (wr_be),
      .init_done  (init_done),
      .parity_err (parity_err)
   );

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      bad_lane0 = '0;
      for (int i = 0; i < 3; i++) begin
         pv[i] = 1'b0; pd[i] = '0; pp[i] = 1'b0;
      end
      last_data = '0;
   endtask

   // One RUN-phase cycle; expected read word and latency come from the model.
   task automatic cyc(input logic re, input logic [3:0] ra, input logic we,
                      input logic [3:0] wa, input logic [71:0] wd, input logic [7:0] be);
      logic [71:0] e;
      logic        ep;
      e  = mdl[ra];
      ep = bad_lane0[ra];
      for (int i = 0; i < 8; i++) begin
         if (we && wa == ra && be[i]) begin
            e[i*9 +: 9] = wd[i*9 +: 9];
            if (i == 0) ep = 1'b0;
         end
      end
      rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
      tick();
      rd_en = 1'b0; wr_en = 1'b0;
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
               mdl[wa][i*9 +: 9] = wd[i*9 +: 9];
               if (i == 0) bad_lane0[wa] = 1'b0;
            end
         end
      end
      pv[2] = pv[1]; pd[2] = pd[1]; pp[2] = pp[1];
      pv[1] = pv[0]; pd[1] = pd[0]; pp[1] = pp[0];
      pv[0] = re;    pd[0] = e;     pp[0] = re & ep;
      check("rd_valid", 72'(rd_valid), 72'(pv[2]));
      if (pv[2]) begin
         check("rd_data", rd_data, pd[2]);
         last_data = pd[2];
      end else begin
         check("rd_hold", rd_data, last_data);
      end
      check("parity_err", 72'(parity_err), 72'(pv[2] & pp[2]));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0, 4'd0, '0, '0);
   endtask

   // Counts edges from reset release until init_done, with accesses attempted throughout.
   task automatic wait_init(output int n);
      n = 0;
      while (!init_done && n < 100) begin
         tick();
         n++;
         check("init_no_valid", 72'(rd_valid), 72'(0));
      end
      rd_en = 1'b0;
      wr_en = 1'b0;
   endtask

   initial begin
      int n;
      logic [71:0] pat_a, pat_b;
      rst_n = 1'b0; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0;
      wr_addr = '0; wr_data = '0; wr_be = '0;
      clear_model();
      repeat (3) tick();
      check("rst_valid", 72'(rd_valid), 72'(0));
      check("rst_init_done", 72'(init_done), 72'(0));
      check("rst_data", rd_data, 72'(0));
      check("rst_perr", 72'(parity_err), 72'(0));

      // Release reset; write and read addr 2 throughout INIT (must be ignored).
      rst_n = 1'b1;
      rd_en = 1'b1; rd_addr = 4'd2;
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 72'h55; wr_be = 8'hFF;
      wait_init(n);
      check("init_cycles", 72'(n), 72'(17));

      for (int a = 0; a < 16; a++) cyc(1'b1, 4'(a), 1'b0, 4'd0, '0, '0);
      idle(3);

      // Latency: write then read the next cycle.
      cyc(1'b0, 4'd0, 1'b1, 4'd5, 72'h0AB, 8'hFF);
      cyc(1'b1, 4'd5, 1'b0, 4'd0, '0, '0);
      idle(4);

      // Same-cycle partial write / read collision.
      cyc(1'b0, 4'd0, 1'b1, 4'd7, '1, 8'hFF);
      cyc(1'b1, 4'd7, 1'b1, 4'd7, '0, 8'h01);
      idle(3);
      cyc(1'b1, 4'd7, 1'b0, 4'd0, '0, '0);
      idle(3);
      check("collide_word", last_data, 72'hFF_FFFF_FFFF_FFFF_FE00);

      // wr_be=0 is a no-op.
      cyc(1'b0, 4'd0, 1'b1, 4'd5, '1, 8'h00);
      cyc(1'b1, 4'd5, 1'b0, 4'd0, '0, '0);
      idle(3);

      // Mixed back-to-back traffic.
      pat_a = 72'h12_3456_789A_BCDE_F012;
      pat_b = 72'hA5_5A5A_A5A5_5A5A_A5A5;
      cyc(1'b0, 4'd0, 1'b1, 4'd1, pat_a, 8'hFF);
      cyc(1'b0, 4'd0, 1'b1, 4'd9, pat_b, 8'hAA);
      cyc(1'b1, 4'd1, 1'b0, 4'd0, '0, '0);
      cyc(1'b1, 4'd9, 1'b1, 4'd1, pat_b, 8'h0F);
      cyc(1'b1, 4'd5, 1'b0, 4'd0, '0, '0);
      cyc(1'b1, 4'd1, 1'b0, 4'd0, '0, '0);
      cyc(1'b1, 4'd7, 1'b0, 4'd0, '0, '0);
      idle(4);

`ifdef STAGE_MEM_PARITY_EN
      dut.u_ram.r_mem[3][0] = ~dut.u_ram.r_mem[3][0];
      mdl[3][0] = ~mdl[3][0];
      bad_lane0[3] = 1'b1;
      cyc(1'b1, 4'd3, 1'b0, 4'd0, '0, '0);
      cyc(1'b1, 4'd4, 1'b0, 4'd0, '0, '0);
      idle(3);
`endif

      // Reset mid-stream: two reads accepted, reset before any rd_valid.
      cyc(1'b1, 4'd1, 1'b0, 4'd0, '0, '0);
      cyc(1'b1, 4'd2, 1'b0, 4'd0, '0, '0);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 72'(rd_valid), 72'(0));
      check("midrst_init_done", 72'(init_done), 72'(0));
      check("midrst_data", rd_data, 72'(0));
      rd_en = 1'b1; rd_addr = 4'd3;
      tick();
      check("midrst_valid2", 72'(rd_valid), 72'(0));
      rst_n = 1'b1;
      rd_addr = 4'd4;
      wait_init(n);
      check("reinit_cycles", 72'(n), 72'(17));
      clear_model();
      cyc(1'b1, 4'd5, 1'b0, 4'd0, '0, '0);
      cyc(1'b1, 4'd7, 1'b0, 4'd0, '0, '0);
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
